// File: rtl/io_port_pkg.sv
// Shared constants for the memory-mapped I/O port controller:
// default register addresses, FIFO depth and status register bit positions.
package io_port_pkg;

  localparam int unsigned DEPTH_DEFAULT     = 4;
  localparam logic [15:0] IN_ADDR_DEFAULT   = 16'h3FFE;
  localparam logic [15:0] OUT_ADDR_DEFAULT  = 16'h3FFC;
  localparam logic [15:0] STAT_ADDR_DEFAULT = 16'h3FFA;

  // Status register layout: [15:11] in_count, [10:6] out_count, [2] irq,
  // [1] out_drop, [0] in_underflow.
  localparam int unsigned STAT_UNDERFLOW_BIT = 0;
  localparam int unsigned STAT_DROP_BIT      = 1;
  localparam int unsigned STAT_IRQ_BIT       = 2;

  // Which mapped register the current CPU address selects.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_IN,
    SEL_OUT,
    SEL_STAT
  } reg_sel_e;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with occupancy count. A push while full is accepted only
// when a pop happens on the same edge; a pop while empty is ignored.
module io_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O port: an input FIFO fed by an external producer and read
// by the CPU, an output FIFO written by the CPU and drained by an external
// consumer, plus a status register with sticky error bits.
// Optional feature macro: IO_PORT_IRQ_EN adds a registered irq output.
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEFAULT,
  parameter logic [15:0] IN_ADDR   = IN_ADDR_DEFAULT,
  parameter logic [15:0] OUT_ADDR  = OUT_ADDR_DEFAULT,
  parameter logic [15:0] STAT_ADDR = STAT_ADDR_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        memw,
  input  logic        memr,
  input  logic [15:0] addr_in,
  input  logic [15:0] dataw_in,
  output logic [15:0] io_rd_data,
  output logic        io_hit,
  input  logic [15:0] ext_in_data,
  input  logic        ext_in_valid,
  output logic        ext_in_ready,
  output logic [15:0] ext_out_data,
  output logic        ext_out_valid,
  input  logic        ext_out_ready
`ifdef IO_PORT_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  reg_sel_e       sel;
  logic [15:0]    in_head;
  logic [CW-1:0]  in_count;
  logic [CW-1:0]  out_count;
  logic           in_full;
  logic           in_empty;
  logic           out_full;
  logic           out_empty;
  logic           in_push;
  logic           in_pop;
  logic           out_push;
  logic           out_pop;
  logic           underflow_set;
  logic           drop_set;
  logic           stat_wr;
  logic           out_drop;
  logic           in_underflow;
  logic           irq_q;
  logic [15:0]    status;

  // Address decode for the three mapped registers.
  always_comb begin
    sel = SEL_NONE;
    if (addr_in == IN_ADDR)        sel = SEL_IN;
    else if (addr_in == OUT_ADDR)  sel = SEL_OUT;
    else if (addr_in == STAT_ADDR) sel = SEL_STAT;
  end

  assign io_hit        = (sel != SEL_NONE);
  assign ext_in_ready  = !in_full;
  assign ext_out_valid = !out_empty;

  assign in_push       = ext_in_valid && ext_in_ready;
  assign in_pop        = memr && (sel == SEL_IN) && !in_empty;
  assign underflow_set = memr && (sel == SEL_IN) && in_empty;
  assign out_pop       = ext_out_valid && ext_out_ready;
  assign out_push      = memw && (sel == SEL_OUT);
  assign drop_set      = out_push && out_full && !out_pop;
  assign stat_wr       = memw && (sel == SEL_STAT);

  io_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_in_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (in_push),
    .pop   (in_pop),
    .wdata (ext_in_data),
    .rdata (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  io_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_out_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (out_push),
    .pop   (out_pop),
    .wdata (dataw_in),
    .rdata (ext_out_data),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  // Sticky error bits: write-1-to-clear, a same-edge set takes priority.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_drop     <= 1'b0;
      in_underflow <= 1'b0;
    end else begin
      out_drop     <= drop_set |
                      (out_drop & ~(stat_wr & dataw_in[STAT_DROP_BIT]));
      in_underflow <= underflow_set |
                      (in_underflow & ~(stat_wr & dataw_in[STAT_UNDERFLOW_BIT]));
    end
  end

`ifdef IO_PORT_IRQ_EN
  // Interrupt flags pending input data or a dropped output write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) irq_q <= 1'b0;
    else     irq_q <= !in_empty || out_drop;
  end
  assign irq = irq_q;
`else
  assign irq_q = 1'b0;
`endif

  // Status register assembly.
  always_comb begin
    status                     = '0;
    status[15:11]              = 5'(in_count);
    status[10:6]               = 5'(out_count);
    status[STAT_IRQ_BIT]       = irq_q;
    status[STAT_DROP_BIT]      = out_drop;
    status[STAT_UNDERFLOW_BIT] = in_underflow;
  end

  // CPU read mux; an empty input FIFO reads as zero.
  always_comb begin
    io_rd_data = '0;
    case (sel)
      SEL_IN:   io_rd_data = in_empty ? 16'h0000 : in_head;
      SEL_STAT: io_rd_data = status;
      default:  io_rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: directed vector table, an async reset
// sequence, randomized traffic against a queue-based model, and (with
// IO_PORT_IRQ_EN) an irq timing sequence.
module tb_io_port_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] A_IN  = 16'h3FFE;
  localparam logic [15:0] A_OUT = 16'h3FFC;
  localparam logic [15:0] A_ST  = 16'h3FFA;
  localparam logic [15:0] A_NO  = 16'h1000;
`ifdef IO_PORT_IRQ_EN
  localparam bit          IRQ_ON = 1'b1;
  localparam logic [15:0] IRQV   = 16'h0004;
`else
  localparam bit          IRQ_ON = 1'b0;
  localparam logic [15:0] IRQV   = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        memw, memr;
  logic [15:0] addr_in, dataw_in;
  logic [15:0] io_rd_data;
  logic        io_hit;
  logic [15:0] ext_in_data;
  logic        ext_in_valid, ext_in_ready;
  logic [15:0] ext_out_data;
  logic        ext_out_valid, ext_out_ready;
`ifdef IO_PORT_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_port_ctrl #(
    .DEPTH     (DEPTH),
    .IN_ADDR   (A_IN),
    .OUT_ADDR  (A_OUT),
    .STAT_ADDR (A_ST)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .memw          (memw),
    .memr          (memr),
    .addr_in       (addr_in),
    .dataw_in      (dataw_in),
    .io_rd_data    (io_rd_data),
    .io_hit        (io_hit),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready)
`ifdef IO_PORT_IRQ_EN
    ,
    .irq           (irq)
`endif
  );

  typedef struct {
    logic        memw;
    logic        memr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        iv;
    logic [15:0] idata;
    logic        ordy;
    logic [15:0] e_rd;
    logic        e_hit;
    logic        e_irdy;
    logic        e_ov;
    logic [15:0] e_od;
  } vec_t;

  vec_t vecs[$];

  // Reference model state.
  logic [15:0] in_q[$];
  logic [15:0] out_q[$];
  bit          m_drop, m_uf, m_irq;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic w, input logic r, input logic [15:0] a, input logic [15:0] wd,
                     input logic iv, input logic [15:0] id, input logic ordy,
                     input logic [15:0] erd, input logic ehit, input logic eirdy,
                     input logic eov, input logic [15:0] eod);
    vec_t v;
    v.memw = w;  v.memr = r;  v.addr = a;  v.wdata = wd;
    v.iv = iv;   v.idata = id; v.ordy = ordy;
    v.e_rd = erd; v.e_hit = ehit; v.e_irdy = eirdy; v.e_ov = eov; v.e_od = eod;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic w, input logic r, input logic [15:0] a, input logic [15:0] wd,
                       input logic iv, input logic [15:0] id, input logic ordy);
    memw = w; memr = r; addr_in = a; dataw_in = wd;
    ext_in_valid = iv; ext_in_data = id; ext_out_ready = ordy;
  endtask

  // Model: outputs before the edge, from queue contents and sticky bits.
  task automatic model_check();
    logic [15:0] exp_rd;
    exp_rd = 16'h0000;
    if (addr_in == A_IN && in_q.size() != 0) exp_rd = in_q[0];
    if (addr_in == A_ST)
      exp_rd = {5'(in_q.size()), 5'(out_q.size()), 3'b000, (IRQ_ON && m_irq), m_drop, m_uf};
    chk("rnd_rd", io_rd_data, exp_rd);
    chk("rnd_hit", 16'(io_hit), 16'(addr_in == A_IN || addr_in == A_OUT || addr_in == A_ST));
    chk("rnd_in_ready", 16'(ext_in_ready), 16'(in_q.size() != DEPTH));
    chk("rnd_out_valid", 16'(ext_out_valid), 16'(out_q.size() != 0));
    if (out_q.size() != 0) chk("rnd_out_data", ext_out_data, out_q[0]);
`ifdef IO_PORT_IRQ_EN
    chk("rnd_irq", 16'(irq), 16'(m_irq));
`endif
  endtask

  // Model: state change at the clock edge.
  task automatic model_step();
    int  isz, osz;
    bit  in_push, in_pop, uf_set, out_pop, out_wr, out_acc, st_wr;
    isz     = in_q.size();
    osz     = out_q.size();
    in_push = ext_in_valid && isz < DEPTH;
    in_pop  = memr && addr_in == A_IN && isz > 0;
    uf_set  = memr && addr_in == A_IN && isz == 0;
    out_pop = osz > 0 && ext_out_ready;
    out_wr  = memw && addr_in == A_OUT;
    out_acc = out_wr && (osz < DEPTH || out_pop);
    st_wr   = memw && addr_in == A_ST;
    m_irq   = (isz != 0) || m_drop;
    m_uf    = uf_set || (m_uf && !(st_wr && dataw_in[0]));
    m_drop  = (out_wr && !out_acc) || (m_drop && !(st_wr && dataw_in[1]));
    if (in_pop)  void'(in_q.pop_front());
    if (in_push) in_q.push_back(ext_in_data);
    if (out_pop) void'(out_q.pop_front());
    if (out_acc) out_q.push_back(dataw_in);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, A_NO, 16'h0, 0, 16'h0, 0);

    // Directed vectors: inputs, then outputs expected before the edge.
    add(0,1,A_ST ,16'h0   ,0,16'h0,0, 16'h0000,1,1,0,16'h0);
    add(1,0,A_OUT,16'h1234,0,16'h0,0, 16'h0000,1,1,0,16'h0);
    add(0,1,A_ST ,16'h0   ,0,16'h0,0, 16'h0040,1,1,1,16'h1234);
    add(0,0,A_NO ,16'h0   ,0,16'h0,1, 16'h0000,0,1,1,16'h1234);
    add(1,0,A_OUT,16'hA001,0,16'h0,0, 16'h0000,1,1,0,16'h0);
    add(1,0,A_OUT,16'hA002,0,16'h0,0, 16'h0000,1,1,1,16'hA001);
    add(1,0,A_OUT,16'hA003,0,16'h0,0, 16'h0000,1,1,1,16'hA001);
    add(1,0,A_OUT,16'hA004,0,16'h0,0, 16'h0000,1,1,1,16'hA001);
    add(1,0,A_OUT,16'hA005,0,16'h0,0, 16'h0000,1,1,1,16'hA001);
    add(0,1,A_ST ,16'h0   ,0,16'h0,0, 16'h0102,1,1,1,16'hA001);
    add(0,0,A_NO ,16'h0   ,0,16'h0,1, 16'h0000,0,1,1,16'hA001);
    add(0,0,A_NO ,16'h0   ,0,16'h0,1, 16'h0000,0,1,1,16'hA002);
    add(0,0,A_NO ,16'h0   ,0,16'h0,1, 16'h0000,0,1,1,16'hA003);
    add(0,0,A_NO ,16'h0   ,0,16'h0,1, 16'h0000,0,1,1,16'hA004);
    add(1,0,A_ST ,16'h0002,0,16'h0,1, 16'h0002 | IRQV,1,1,0,16'h0);
    add(1,0,A_OUT,16'hB001,0,16'h0,0, 16'h0000,1,1,0,16'h0);
    add(1,0,A_OUT,16'hB002,0,16'h0,0, 16'h0000,1,1,1,16'hB001);
    add(1,0,A_OUT,16'hB003,0,16'h0,0, 16'h0000,1,1,1,16'hB001);
    add(1,0,A_OUT,16'hB004,0,16'h0,0, 16'h0000,1,1,1,16'hB001);
    add(1,0,A_OUT,16'hBEEF,0,16'h0,1, 16'h0000,1,1,1,16'hB001);
    add(0,1,A_ST ,16'h0   ,0,16'h0,0, 16'h0100,1,1,1,16'hB002);
    add(0,0,A_NO ,16'h0   ,0,16'h0,1, 16'h0000,0,1,1,16'hB002);
    add(0,0,A_NO ,16'h0   ,0,16'h0,1, 16'h0000,0,1,1,16'hB003);
    add(0,0,A_NO ,16'h0   ,0,16'h0,1, 16'h0000,0,1,1,16'hB004);
    add(0,0,A_NO ,16'h0   ,0,16'h0,1, 16'h0000,0,1,1,16'hBEEF);
    add(0,0,A_NO ,16'h0   ,1,16'h00FF,0, 16'h0000,0,1,0,16'h0);
    add(0,0,A_IN ,16'h0   ,1,16'h0100,0, 16'h00FF,1,1,0,16'h0);
    add(0,1,A_IN ,16'h0   ,0,16'h0,0, 16'h00FF,1,1,0,16'h0);
    add(0,1,A_IN ,16'h0   ,0,16'h0,0, 16'h0100,1,1,0,16'h0);
    add(0,1,A_IN ,16'h0   ,0,16'h0,0, 16'h0000,1,1,0,16'h0);
    add(0,1,A_ST ,16'h0   ,0,16'h0,0, 16'h0001,1,1,0,16'h0);
    add(1,0,A_ST ,16'h0001,0,16'h0,0, 16'h0001,1,1,0,16'h0);
    add(0,1,A_ST ,16'h0   ,0,16'h0,0, 16'h0000,1,1,0,16'h0);
    add(1,0,A_OUT,16'hD001,1,16'hC001,0, 16'h0000,1,1,0,16'h0);
    add(1,0,A_OUT,16'hD002,1,16'hC002,0, 16'h0000,1,1,1,16'hD001);
    add(1,0,A_OUT,16'hD003,1,16'hC003,0, 16'h0000,1,1,1,16'hD001);
    add(0,1,A_ST ,16'h0   ,0,16'h0,0, 16'h18C0 | IRQV,1,1,1,16'hD001);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].memw, vecs[i].memr, vecs[i].addr, vecs[i].wdata,
            vecs[i].iv, vecs[i].idata, vecs[i].ordy);
      @(negedge clk);
      chk($sformatf("vec%0d_rd", i), io_rd_data, vecs[i].e_rd);
      chk($sformatf("vec%0d_hit", i), 16'(io_hit), 16'(vecs[i].e_hit));
      chk($sformatf("vec%0d_in_ready", i), 16'(ext_in_ready), 16'(vecs[i].e_irdy));
      chk($sformatf("vec%0d_out_valid", i), 16'(ext_out_valid), 16'(vecs[i].e_ov));
      if (vecs[i].e_ov) chk($sformatf("vec%0d_out_data", i), ext_out_data, vecs[i].e_od);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset with three entries queued in each direction.
    drive(0, 1, A_ST, 16'h0, 0, 16'h0, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 16'(ext_out_valid), 16'h0000);
    chk("async_rst_in_ready", 16'(ext_in_ready), 16'h0001);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_status", io_rd_data, 16'h0000);
    chk("post_rst_out_valid", 16'(ext_out_valid), 16'h0000);
    @(posedge clk);
    #1;

    // Randomized traffic: first biased to fill, then biased to drain.
    in_q.delete(); out_q.delete();
    m_drop = 0; m_uf = 0; m_irq = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int unsigned fill;
      logic [15:0] a;
      fill = (cyc < 1000) ? 1 : 0;
      case ($urandom_range(3))
        0:       a = A_IN;
        1:       a = A_OUT;
        2:       a = A_ST;
        default: a = A_NO;
      endcase
      drive($urandom_range(99) < 50, $urandom_range(99) < (fill ? 30 : 70), a, 16'($urandom),
            $urandom_range(99) < (fill ? 80 : 20), 16'($urandom),
            $urandom_range(99) < (fill ? 20 : 80));
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_step();
      #1;
    end

`ifdef IO_PORT_IRQ_EN
    // irq follows an external push and the final CPU pop one edge late.
    drive(0, 0, A_NO, 16'h0, 0, 16'h0, 0);
    rst = 1'b1;
    #1 rst = 1'b0;
    drive(0, 0, A_NO, 16'h0, 1, 16'h5555, 0);
    @(posedge clk); #1;
    drive(0, 0, A_NO, 16'h0, 0, 16'h0, 0);
    chk("irq_after_push_edge", 16'(irq), 16'h0000);
    @(posedge clk); #1;
    chk("irq_one_cycle_later", 16'(irq), 16'h0001);
    drive(0, 1, A_IN, 16'h0, 0, 16'h0, 0);
    @(posedge clk); #1;
    drive(0, 0, A_NO, 16'h0, 0, 16'h0, 0);
    chk("irq_after_pop_edge", 16'(irq), 16'h0001);
    @(posedge clk); #1;
    chk("irq_cleared", 16'(irq), 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
